// File: rtl/jk_bank_driver_if.sv
// Handshake and bank-side signals of the JK flip-flop bank driver.
// The slave modport is the driver's view; master is the environment's view.
interface jk_bank_driver_if #(
    parameter int WIDTH = 8
) ();
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] err_mask;

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, j, k, busy, done, err, err_mask
    );

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, j, k, busy, done, err, err_mask
    );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flip-flops to a target word, verifies the result on q_fb
// and re-drives mismatched bits up to MAX_RETRY times before flagging an error.
module jk_bank_driver #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3,
    parameter int TOGGLE_EN = 1
) (
    input logic             clk,
    input logic             rst,
    jk_bank_driver_if.slave bus
);
    localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] err_mask_r;
    logic [WIDTH-1:0] j_c, k_c;
    logic [CW-1:0]    retry_cnt;
    logic             done_r, err_r;
    logic             tgt_ready_c, busy_c;
    logic             accept, match, last_try;

    assign diff     = bus.q_fb ^ tgt_r;
    assign match    = (diff == '0);
    assign accept   = (state == IDLE) && bus.tgt_valid;
    assign last_try = (retry_cnt == MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE:   state_nxt = CHECK;
            CHECK:   if (match || last_try) state_nxt = IDLE;
                     else                   state_nxt = DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // Target, retry count and result flags; done/err are registered so they
    // appear in the first IDLE cycle after the deciding CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_r      <= '0;
            retry_cnt  <= '0;
            err_mask_r <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= (state == CHECK) && match;
            err_r  <= (state == CHECK) && !match && last_try;
            if (accept) begin
                tgt_r      <= bus.tgt_data;
                retry_cnt  <= '0;
                err_mask_r <= '0;
            end else if ((state == CHECK) && !match) begin
                if (last_try) err_mask_r <= diff;
                else          retry_cnt  <= retry_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        j_c         = '0;
        k_c         = '0;
        tgt_ready_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                tgt_ready_c = 1'b1;
                busy_c      = 1'b0;
            end
            DRIVE: begin
                if (TOGGLE_EN != 0) begin
                    j_c = diff;
                    k_c = diff;
                end else begin
                    j_c = tgt_r & diff;
                    k_c = ~tgt_r & diff;
                end
            end
            default: ;
        endcase
    end

    assign bus.j         = j_c;
    assign bus.k         = k_c;
    assign bus.tgt_ready = tgt_ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.err_mask  = err_mask_r;
endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: two drivers (toggle and set/reset excitation), each on an
// ideal JK bank model with a per-bit stuck-at-0 mask and a preload port.
module tb_jk_bank_driver;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic       load_a, load_b;
    logic [7:0] load_val;
    logic [7:0] stuck_a;

    jk_bank_driver_if #(.WIDTH(8)) bus_a ();
    jk_bank_driver_if #(.WIDTH(8)) bus_b ();

    jk_bank_driver #(.WIDTH(8), .MAX_RETRY(3), .TOGGLE_EN(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    jk_bank_driver #(.WIDTH(8), .MAX_RETRY(3), .TOGGLE_EN(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal JK bank: Q+ = J&~Q | ~K&Q, with optional preload and stuck-at-0 bits.
    always @(posedge clk) begin
        if (load_a) bus_a.q_fb <= load_val;
        else        bus_a.q_fb <= ((bus_a.j & ~bus_a.q_fb) | (~bus_a.k & bus_a.q_fb)) & ~stuck_a;
        if (load_b) bus_b.q_fb <= load_val;
        else        bus_b.q_fb <= (bus_b.j & ~bus_b.q_fb) | (~bus_b.k & bus_b.q_fb);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel_b, input logic valid, input logic [7:0] data);
        if (sel_b) begin
            bus_b.tgt_valid = valid;
            bus_b.tgt_data  = data;
        end else begin
            bus_a.tgt_valid = valid;
            bus_a.tgt_data  = data;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst      = 1'b1;
        load_a   = 1'b1;
        load_b   = 1'b1;
        load_val = 8'h00;
        stuck_a  = 8'h00;
        applyStimulus(0, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, 8'h00);
        step();
        step();
        rst    = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;

        // Reset state
        checkOutput("rst_ready", {31'd0, bus_a.tgt_ready}, 32'd1);
        checkOutput("rst_busy",  {31'd0, bus_a.busy},      32'd0);
        checkOutput("rst_jk",    {16'd0, bus_a.j, bus_a.k}, 32'd0);
        checkOutput("rst_flags", {30'd0, bus_a.done, bus_a.err}, 32'd0);
        checkOutput("rst_mask",  {24'd0, bus_a.err_mask}, 32'd0);
        checkOutput("rst_b_jk",  {16'd0, bus_b.j, bus_b.k}, 32'd0);

        // Toggle excitation: q=00 -> A5
        applyStimulus(0, 1'b1, 8'hA5);
        step();
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput("t1_drv_busy",  {31'd0, bus_a.busy},      32'd1);
        checkOutput("t1_drv_ready", {31'd0, bus_a.tgt_ready}, 32'd0);
        checkOutput("t1_drv_j",     {24'd0, bus_a.j},         32'hA5);
        checkOutput("t1_drv_k",     {24'd0, bus_a.k},         32'hA5);
        step();
        checkOutput("t1_chk_jk",    {16'd0, bus_a.j, bus_a.k}, 32'd0);
        checkOutput("t1_chk_q",     {24'd0, bus_a.q_fb},      32'hA5);
        checkOutput("t1_chk_done",  {31'd0, bus_a.done},      32'd0);
        step();
        checkOutput("t1_done",      {30'd0, bus_a.done, bus_a.err}, 32'd2);
        checkOutput("t1_idle",      {30'd0, bus_a.tgt_ready, bus_a.busy}, 32'd2);
        step();
        checkOutput("t1_done_pulse", {31'd0, bus_a.done}, 32'd0);

        // Set/reset excitation: q=F0 -> 3C
        load_b   = 1'b1;
        load_val = 8'hF0;
        step();
        load_b = 1'b0;
        applyStimulus(1, 1'b1, 8'h3C);
        step();
        applyStimulus(1, 1'b0, 8'h00);
        checkOutput("t2_drv_j", {24'd0, bus_b.j}, 32'h0C);
        checkOutput("t2_drv_k", {24'd0, bus_b.k}, 32'hC0);
        step();
        checkOutput("t2_chk_q",  {24'd0, bus_b.q_fb}, 32'h3C);
        checkOutput("t2_chk_jk", {16'd0, bus_b.j, bus_b.k}, 32'd0);
        step();
        checkOutput("t2_done", {30'd0, bus_b.done, bus_b.err}, 32'd2);

        // Target already present: q=5A -> 5A
        load_a   = 1'b1;
        load_val = 8'h5A;
        step();
        load_a = 1'b0;
        applyStimulus(0, 1'b1, 8'h5A);
        step();
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput("t3_drv_jk",   {16'd0, bus_a.j, bus_a.k}, 32'd0);
        checkOutput("t3_drv_busy", {31'd0, bus_a.busy}, 32'd1);
        step();
        checkOutput("t3_chk_jk", {16'd0, bus_a.j, bus_a.k}, 32'd0);
        step();
        checkOutput("t3_done", {30'd0, bus_a.done, bus_a.err}, 32'd2);

        // Bit 0 stuck at 0: four attempts, err in cycle 9
        load_a   = 1'b1;
        load_val = 8'h00;
        stuck_a  = 8'h01;
        step();
        load_a = 1'b0;
        applyStimulus(0, 1'b1, 8'h01);
        step();
        applyStimulus(0, 1'b0, 8'h00);
        for (int a = 0; a < 4; a++) begin
            checkOutput($sformatf("t4_drv%0d_jk", a), {16'd0, bus_a.j, bus_a.k}, 32'h0101);
            checkOutput($sformatf("t4_drv%0d_flags", a), {30'd0, bus_a.done, bus_a.err}, 32'd0);
            step();
            checkOutput($sformatf("t4_chk%0d_q", a), {24'd0, bus_a.q_fb}, 32'h00);
            checkOutput($sformatf("t4_chk%0d_flags", a), {30'd0, bus_a.done, bus_a.err}, 32'd0);
            step();
        end
        checkOutput("t4_err",  {30'd0, bus_a.done, bus_a.err}, 32'd1);
        checkOutput("t4_mask", {24'd0, bus_a.err_mask}, 32'h01);
        checkOutput("t4_idle", {30'd0, bus_a.tgt_ready, bus_a.busy}, 32'd2);
        step();
        checkOutput("t4_err_pulse", {30'd0, bus_a.done, bus_a.err}, 32'd0);
        checkOutput("t4_mask_held", {24'd0, bus_a.err_mask}, 32'h01);

        // Reset during CHECK: no pulse afterwards; accept clears err_mask
        stuck_a = 8'h00;
        applyStimulus(0, 1'b1, 8'hFF);
        step();
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput("t5_mask_clr", {24'd0, bus_a.err_mask}, 32'h00);
        checkOutput("t5_drv_j",    {24'd0, bus_a.j}, 32'hFF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("t5_rst_jk",    {16'd0, bus_a.j, bus_a.k}, 32'd0);
        checkOutput("t5_rst_idle",  {30'd0, bus_a.tgt_ready, bus_a.busy}, 32'd2);
        checkOutput("t5_rst_flags", {30'd0, bus_a.done, bus_a.err}, 32'd0);
        step();
        checkOutput("t5_post_flags", {30'd0, bus_a.done, bus_a.err}, 32'd0);
        checkOutput("t5_post_busy",  {31'd0, bus_a.busy}, 32'd0);

        // Back-to-back targets with tgt_valid held: q=FF -> 11 -> 22
        applyStimulus(0, 1'b1, 8'h11);
        step();
        applyStimulus(0, 1'b1, 8'h22);
        checkOutput("t6_drv1_j", {24'd0, bus_a.j}, 32'hEE);
        step();
        checkOutput("t6_chk1_q", {24'd0, bus_a.q_fb}, 32'h11);
        step();
        checkOutput("t6_done1",  {30'd0, bus_a.done, bus_a.err}, 32'd2);
        checkOutput("t6_ready1", {31'd0, bus_a.tgt_ready}, 32'd1);
        step();
        applyStimulus(0, 1'b0, 8'h00);
        checkOutput("t6_drv2_jk", {16'd0, bus_a.j, bus_a.k}, 32'h3333);
        checkOutput("t6_drv2_flags", {30'd0, bus_a.done, bus_a.err}, 32'd0);
        step();
        checkOutput("t6_chk2_q", {24'd0, bus_a.q_fb}, 32'h22);
        step();
        checkOutput("t6_done2",  {30'd0, bus_a.done, bus_a.err}, 32'd2);
        checkOutput("t6_q2",     {24'd0, bus_a.q_fb}, 32'h22);
        step();
        checkOutput("t6_quiet",  {30'd0, bus_a.done, bus_a.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_bank_driver.md
JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

Interface
REQ-001 Parameter WIDTH, default 8: number of JK flip-flops driven.
REQ-002 Parameter MAX_RETRY, default 3: re-drive attempts after a failed check.
REQ-003 Parameter TOGGLE_EN, default 1: 1 selects the toggle excitation (J=K=1) for bits that must change; 0 selects set/reset excitation.
REQ-004 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 tgt_valid  input  1  target word offered.
REQ-007 tgt_data  input  WIDTH  target value for the flip-flop bank.
REQ-008 tgt_ready  output  1  block can accept a target.
REQ-009 q_fb  input  WIDTH  q outputs of the driven JK flip-flop bank, which samples on the same clk edge.
REQ-010 j  output  WIDTH  J inputs of the bank.
REQ-011 k  output  WIDTH  K inputs of the bank.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse: the bank reached the target.
REQ-014 err  output  1  one-cycle pulse: the retries are exhausted.
REQ-015 err_mask  output  WIDTH  bits still mismatched at the final failed check; held until the next accept.

Function
REQ-016 The FSM SHALL have three states: IDLE, DRIVE and CHECK.
REQ-017 IDLE: tgt_ready=1, j=0 and k=0 (hold); on tgt_valid&&tgt_ready the block SHALL capture tgt_data into tgt_r, clear the retry count and err_mask, and go to DRIVE.
REQ-018 DRIVE lasts one cycle; with diff=q_fb^tgt_r, j and k SHALL be decoded combinationally from tgt_r and q_fb.
REQ-019 DRIVE with TOGGLE_EN=1: j=diff and k=diff.
REQ-020 DRIVE with TOGGLE_EN=0: j=tgt_r&diff and k=~tgt_r&diff.
REQ-021 Bits with diff=0 SHALL get j=k=0, so no bit is disturbed unnecessarily.
REQ-022 DRIVE SHALL always advance to CHECK.
REQ-023 CHECK lasts one cycle with j=k=0; on q_fb==tgt_r the block SHALL go to IDLE and register done=1 for the following cycle.
REQ-024 CHECK mismatch with retry count < MAX_RETRY: increment the count and go to DRIVE.
REQ-025 CHECK mismatch with retry count == MAX_RETRY: go to IDLE, register err=1 for the following cycle, and load err_mask=q_fb^tgt_r.
REQ-026 j and k SHALL be nonzero only in DRIVE; j&k SHALL be 0 whenever TOGGLE_EN=0.
REQ-027 Latency: accept at edge E0, DRIVE in cycle 1, CHECK in cycle 2, done in cycle 3 (IDLE, tgt_ready=1); each retry adds 2 cycles.
REQ-028 A new target SHALL be acceptable in the same cycle that done or err is high.
REQ-029 A target equal to q_fb at accept SHALL still pass DRIVE (j=k=0) and CHECK, giving done at cycle 3.
REQ-030 tgt_data changes while busy SHALL be ignored; only tgt_r is used.
REQ-031 The retry counter SHALL be wide enough for MAX_RETRY; MAX_RETRY=0 means a single attempt.
REQ-032 done and err SHALL never be high in the same cycle.

Reset
REQ-033 rst SHALL take priority over all other inputs, in any state.
REQ-034 On the edge where rst=1 the block SHALL return to IDLE with tgt_r=0, retry count=0, err_mask=0, done=0 and err=0.
REQ-035 From the cycle after that edge, j=k=0, busy=0 and tgt_ready=1.
REQ-036 An operation interrupted by reset SHALL produce no done or err pulse.

Verification (WIDTH=8, bench models an ideal JK bank on q_fb)
REQ-037 After reset, q=0x00, TOGGLE_EN=1, target 0xA5 -> DRIVE j=k=0xA5; CHECK q_fb=0xA5; done at cycle 3; err=0.
REQ-038 TOGGLE_EN=0, q=0xF0, target 0x3C -> DRIVE j=0x0C, k=0xC0; q_fb=0x3C; done at cycle 3.
REQ-039 q=0x5A, target 0x5A -> j=k=0x00 in every cycle; done at cycle 3.
REQ-040 Bit 0 stuck at 0, target 0x01, MAX_RETRY=3 -> 4 DRIVE cycles; err pulse at cycle 9; err_mask=0x01; done never high.
REQ-041 rst=1 during CHECK -> next cycle IDLE, j=k=0, tgt_ready=1, busy=0; no done or err.
REQ-042 tgt_valid held high with targets 0x11 then 0x22 -> second target accepted in the done cycle of the first; second done 3 cycles later; q_fb=0x22.
